// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 5-bit-opcode core.
// Drives the PC/IR/register-file/memory strobes and keeps halt, timeout and retire bookkeeping.
module instr_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_rdy,
    input  logic             dmem_rdy,
    input  logic             dec_halt,
    input  logic             dec_reg_write,
    input  logic             dec_mem_write,
    input  logic             dec_sel_wb,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_en,
    output logic             halted,
    output logic             mem_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] stall_cnt
);

    // Wait counter only needs to reach MEM_TIMEOUT-1; the timeout fires on that cycle.
    localparam int unsigned WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam int unsigned WAIT_LAST = (MEM_TIMEOUT < 1) ? 0 : MEM_TIMEOUT - 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic              f_halt_q, f_halt_d;
    logic              f_reg_write_q, f_reg_write_d;
    logic              f_mem_write_q, f_mem_write_d;
    logic              f_sel_wb_q, f_sel_wb_d;
    logic              mem_err_q, mem_err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              stall_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            f_halt_q      <= 1'b0;
            f_reg_write_q <= 1'b0;
            f_mem_write_q <= 1'b0;
            f_sel_wb_q    <= 1'b0;
            mem_err_q     <= 1'b0;
            wait_q        <= '0;
            instret_q     <= '0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            f_halt_q      <= f_halt_d;
            f_reg_write_q <= f_reg_write_d;
            f_mem_write_q <= f_mem_write_d;
            f_sel_wb_q    <= f_sel_wb_d;
            mem_err_q     <= mem_err_d;
            wait_q        <= wait_d;
            instret_q     <= instret_d;
            stall_q       <= stall_d;
        end
    end

    // Next-state, strobes (Moore from state, Mealy for ir_load/pc_en) and bookkeeping.
    always_comb begin
        state_d       = state_q;
        f_halt_d      = f_halt_q;
        f_reg_write_d = f_reg_write_q;
        f_mem_write_d = f_mem_write_q;
        f_sel_wb_d    = f_sel_wb_q;
        mem_err_d     = mem_err_q;
        wait_d        = wait_q;
        stall_inc     = 1'b0;
        imem_req      = 1'b0;
        ir_load       = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        rf_we         = 1'b0;
        pc_en         = 1'b0;
        halted        = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_rdy) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    stall_inc = 1'b1;
                end
            end
            S_DECODE: begin
                f_halt_d      = dec_halt;
                f_reg_write_d = dec_reg_write;
                f_mem_write_d = dec_mem_write;
                f_sel_wb_d    = dec_sel_wb;
                state_d       = dec_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (f_mem_write_q || f_sel_wb_q) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else if (f_reg_write_q) begin
                    state_d = S_WB;
                end else begin
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = f_mem_write_q;
                if (dmem_rdy) begin
                    if (f_sel_wb_q) begin
                        state_d = S_WB;
                    end else begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    stall_inc = 1'b1;
                    if (wait_q == WAIT_W'(WAIT_LAST)) begin
                        mem_err_d = 1'b1;
                        state_d   = S_HALT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        instret_d = pc_en     ? instret_q + CNT_W'(1) : instret_q;
        stall_d   = stall_inc ? stall_q + CNT_W'(1)   : stall_q;
    end

    assign state     = 3'(state_q);
    assign mem_err   = mem_err_q;
    assign instret   = instret_q;
    assign stall_cnt = stall_q;

endmodule
